// File: rtl/ld_scalar_mult.sv
// Left-to-right double-and-add scalar multiplier driving a combinational point ALU.
// Q = k*P in projective coordinates, points packed as {Z, Y, X}.
module ld_scalar_mult #(
    parameter int unsigned K_WIDTH = 4,
    parameter logic [11:0] INF_PT  = 12'h010
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [K_WIDTH-1:0] k,
    input  logic [11:0]        P,
    output logic               busy,
    output logic               done,
    output logic [11:0]        Q,
    output logic               alu_op,
    output logic [11:0]        alu_a,
    output logic [11:0]        alu_b,
    input  logic [11:0]        alu_r
);

    localparam int unsigned IDX_W = (K_WIDTH > 1) ? $clog2(K_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_DBL,
        S_ADD,
        S_DONE
    } state_t;

    state_t             state;
    logic [K_WIDTH-1:0] kl;
    logic [11:0]        pl;
    logic [11:0]        r;
    logic [IDX_W-1:0]   idx;
    logic               kbit;
    logic               idx_zero;

    assign kbit     = kl[idx];
    assign idx_zero = (idx == '0);

    // Operands are always the accumulator and the latched base point; only the op is state-dependent.
    assign alu_a = r;
    assign alu_b = pl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            kl     <= '0;
            pl     <= '0;
            r      <= '0;
            idx    <= '0;
            Q      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            alu_op <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        kl    <= k;
                        pl    <= P;
                        idx   <= IDX_W'(K_WIDTH - 1);
                        state <= S_SCAN;
                        busy  <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (kbit) begin
                        r <= pl;
                        if (idx_zero) begin
                            Q     <= pl;
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            idx    <= idx - 1'b1;
                            state  <= S_DBL;
                            alu_op <= 1'b1;
                        end
                    end else if (idx_zero) begin
                        r     <= INF_PT;
                        Q     <= INF_PT;
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                S_DBL: begin
                    r <= alu_r;
                    // idx stays put into ADD: the add belongs to the same bit as this double.
                    if (kbit) begin
                        state  <= S_ADD;
                        alu_op <= 1'b0;
                    end else if (idx_zero) begin
                        Q      <= alu_r;
                        state  <= S_DONE;
                        done   <= 1'b1;
                        alu_op <= 1'b0;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                S_ADD: begin
                    r <= alu_r;
                    if (idx_zero) begin
                        Q     <= alu_r;
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        idx    <= idx - 1'b1;
                        state  <= S_DBL;
                        alu_op <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    alu_op <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ld_scalar_mult.sv
// Randomized bench for ld_scalar_mult: a stand-in point ALU plus a per-cycle expected-trace model.
module tb_ld_scalar_mult;

    localparam int          KW  = 4;
    localparam logic [11:0] INF = 12'h010;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic [KW-1:0] k_in  = '0;
    logic [11:0]   p_in  = '0;
    logic          busy, done, alu_op;
    logic [11:0]   Q, alu_a, alu_b, alu_r;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [11:0] f_dbl(input logic [11:0] a);
        return {a[10:0], a[11]} ^ 12'h5A7;
    endfunction

    function automatic logic [11:0] f_add(input logic [11:0] a, input logic [11:0] b);
        logic [11:0] t;
        t = a + b * 12'd3;
        return t ^ 12'h0C3;
    endfunction

    assign alu_r = alu_op ? f_dbl(alu_a) : f_add(alu_a, alu_b);

    ld_scalar_mult #(.K_WIDTH(KW), .INF_PT(INF)) dut (
        .clk(clk), .rst(rst), .start(start), .k(k_in), .P(p_in),
        .busy(busy), .done(done), .Q(Q),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r)
    );

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] ref_mult(input logic [KW-1:0] kk, input logic [11:0] pp);
        logic [11:0] acc;
        bit          seen;
        acc  = INF;
        seen = 0;
        for (int i = KW - 1; i >= 0; i--) begin
            if (seen) acc = f_dbl(acc);
            if (kk[i]) begin
                acc  = seen ? f_add(acc, pp) : pp;
                seen = 1;
            end
        end
        return acc;
    endfunction

    function automatic int exp_cycles(input logic [KW-1:0] kk);
        int m, pc;
        m  = -1;
        pc = 0;
        for (int i = 0; i < KW; i++) if (kk[i]) m = i;
        if (m < 0) return KW + 1;
        for (int i = 0; i < m; i++) if (kk[i]) pc++;
        return (KW - 1 - m) + 1 + m + pc + 1;
    endfunction

    // Expected outputs for one cycle.
    typedef struct packed {
        logic        busy;
        logic        done;
        logic        op;
        logic [11:0] a;
        logic [11:0] b;
        logic [11:0] q;
    } exp_t;

    function automatic exp_t mk(input logic bz, input logic dn, input logic op,
                                input logic [11:0] a, input logic [11:0] b, input logic [11:0] q);
        exp_t e;
        e.busy = bz; e.done = dn; e.op = op; e.a = a; e.b = b; e.q = q;
        return e;
    endfunction

    exp_t        trace[$];
    exp_t        cur = '0;
    logic [11:0] r_m = '0;
    logic [11:0] p_m = '0;
    logic [11:0] qh  = '0;

    // Expands one accepted request into the full list of expected cycles up to and including done.
    task automatic build(input logic [KW-1:0] kk, input logic [11:0] pp);
        int          m;
        int          nscan;
        logic [11:0] acc;
        m = -1;
        for (int i = 0; i < KW; i++) if (kk[i]) m = i;
        nscan = (m < 0) ? KW : KW - m;
        acc   = r_m;
        for (int i = 0; i < nscan; i++) trace.push_back(mk(1'b1, 1'b0, 1'b0, acc, pp, qh));
        acc = (m < 0) ? INF : pp;
        for (int i = m - 1; i >= 0; i--) begin
            trace.push_back(mk(1'b1, 1'b0, 1'b1, acc, pp, qh));
            acc = f_dbl(acc);
            if (kk[i]) begin
                trace.push_back(mk(1'b1, 1'b0, 1'b0, acc, pp, qh));
                acc = f_add(acc, pp);
            end
        end
        trace.push_back(mk(1'b1, 1'b1, 1'b0, acc, pp, acc));
        r_m = acc;
        p_m = pp;
        qh  = acc;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            trace.delete();
            r_m = '0;
            p_m = '0;
            qh  = '0;
            cur = '0;
        end else begin
            if (!cur.busy && start) build(k_in, p_in);
            if (trace.size() > 0) cur = trace.pop_front();
            else                  cur = mk(1'b0, 1'b0, 1'b0, r_m, p_m, qh);
        end
    end

    always @(negedge clk) begin
        chk("busy",   {11'd0, busy},   {11'd0, cur.busy});
        chk("done",   {11'd0, done},   {11'd0, cur.done});
        chk("alu_op", {11'd0, alu_op}, {11'd0, cur.op});
        chk("alu_a",  alu_a, cur.a);
        chk("alu_b",  alu_b, cur.b);
        chk("Q",      Q,     cur.q);
    end

    // Called at the falling edge of an idle cycle; returns there with start low.
    task automatic run_op(input logic [KW-1:0] kk, input logic [11:0] pp, input bit pulse,
                          output int cyc, output logic [31:0] ops);
        k_in  = kk;
        p_in  = pp;
        start = 1'b1;
        cyc   = 0;
        ops   = '0;
        do begin
            @(negedge clk);
            cyc++;
            ops   = {ops[30:0], alu_op};
            start = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
            k_in  = KW'($urandom);
            p_in  = 12'($urandom);
        end while (!done && cyc < 3 * KW + 4);
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: no done within %0d cycles for k=%h", cyc, kk);
        end
        start = pulse ? 1'b1 : 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int          cyc, cyc2;
        logic [31:0] ops;
        logic [KW-1:0] kr;
        logic [11:0] pr;

        chk("pin_k0",  ref_mult(4'h0, 12'h1A3), 12'h010);
        chk("pin_k1",  ref_mult(4'h1, 12'h1A3), 12'h1A3);
        chk("pin_k2",  ref_mult(4'h2, 12'h1A3), 12'h6E1);
        chk("pin_k3",  ref_mult(4'h3, 12'h1A3), 12'hB09);

        repeat (3) @(negedge clk);
        rst = 1'b0;

        run_op(4'h0, 12'h1A3, 0, cyc, ops);
        chk("k0_cycles", 12'(cyc), 12'd5);
        chk("k0_ops",    12'(ops[4:0]), 12'b00000);
        chk("k0_Q",      Q, 12'h010);

        run_op(4'h1, 12'h1A3, 0, cyc, ops);
        chk("k1_cycles", 12'(cyc), 12'd5);
        chk("k1_Q",      Q, 12'h1A3);

        run_op(4'hB, 12'h1A3, 0, cyc, ops);
        chk("kB_cycles", 12'(cyc), 12'd7);
        chk("kB_ops",    12'(ops[6:0]), 12'b0110100);
        chk("kB_Q",      Q, ref_mult(4'hB, 12'h1A3));

        run_op(4'h8, 12'h2C5, 1, cyc, ops);
        chk("k8_cycles", 12'(cyc), 12'd5);
        chk("k8_ops",    12'(ops[4:0]), 12'b01110);
        chk("k8_Q",      Q, ref_mult(4'h8, 12'h2C5));

        // Reset during a DBL cycle of k=F.
        k_in  = 4'hF;
        p_in  = 12'h1A3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", {11'd0, busy}, 12'd0);
        chk("rst_done", {11'd0, done}, 12'd0);
        chk("rst_Q",    Q, 12'h000);
        @(negedge clk);
        rst = 1'b0;
        run_op(4'h5, 12'h3E7, 0, cyc, ops);
        chk("post_rst_Q", Q, ref_mult(4'h5, 12'h3E7));

        // Back-to-back with start held high: k=3 then k=2.
        p_in  = 12'h1A3;
        k_in  = 4'h3;
        start = 1'b1;
        cyc   = 0;
        do begin
            @(negedge clk);
            cyc++;
            k_in = 4'h2;
        end while (!done && cyc < 20);
        chk("b2b_cyc1", 12'(cyc), 12'd6);
        chk("b2b_Q1",   Q, 12'hB09);
        @(negedge clk);
        chk("b2b_gap_busy", {11'd0, busy}, 12'd0);
        cyc2 = 0;
        do begin
            @(negedge clk);
            cyc2++;
            start = 1'b0;
            if (!done) chk("b2b_Q_hold", Q, 12'hB09);
        end while (!done && cyc2 < 20);
        chk("b2b_cyc2", 12'(cyc2), 12'd5);
        chk("b2b_Q2",   Q, 12'h6E1);
        @(negedge clk);

        for (int n = 0; n < 150; n++) begin
            kr = KW'($urandom);
            pr = 12'($urandom);
            run_op(kr, pr, bit'($urandom_range(0, 1)), cyc, ops);
            chk("rnd_cycles", 12'(cyc), 12'(exp_cycles(kr)));
            chk("rnd_Q",      Q, ref_mult(kr, pr));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
